mips_multicycle_top: RTL and testbench



---
 rtl/mips_pkg.sv | 103 ++++++++++
 rtl/mips_mc_datapath.sv | 143 ++++++++++++++
 rtl/mips_mc_mem.sv | 36 +++
 rtl/mips_mc_regfile.sv | 38 +++
 rtl/mips_multicycle_top.sv | 133 +++++++++++++
 tb/tb_mips_multicycle_top.sv | 322 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mips_pkg                                               |
// | Description : Shared definitions for the multi-cycle MIPS subset:    |
// |               opcode/funct codes, controller states, ALU operations  |
// |               and the control bundle passed from the controller to   |
// |               the datapath.                                          |
// | Ports       : none (package)                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mips_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctrl_t;

  // ALU B-operand source
  typedef enum logic [1:0] {
    SRCB_B       = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } srcb_t;

  // Next-PC source
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pcsrc_t;

  typedef struct packed {
    logic      ir_we;      // capture instruction word
    logic      ab_we;      // capture register operands
    logic      mdr_we;     // capture memory read data
    logic      aluout_we;  // capture ALU result
    logic      pc_we;      // unconditional PC update
    logic      pc_we_beq;  // PC update only when A == B
    pcsrc_t    pc_src;
    logic      iord;       // 0: address from PC, 1: address from ALUOut
    logic      mem_we;
    logic      srca_reg;   // 0: PC, 1: A
    srcb_t     srcb;
    alu_ctrl_t alu_ctrl;
    logic      reg_we;
    logic      reg_dst_rd; // 0: rt, 1: rd
    logic      mem_to_reg; // 0: ALUOut, 1: MDR
  } ctrl_t;

  function automatic logic funct_valid(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  // Unknown functs fall back to ADD; their writeback is suppressed anyway.
  function automatic alu_ctrl_t funct_to_alu(input logic [5:0] fn);
    alu_ctrl_t op;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mc_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mips_mc_datapath                                       |
// | Description : Multi-cycle MIPS datapath: PC, IR, MDR, A, B, ALUOut   |
// |               registers, ALU, operand muxes, unified memory (MEM)    |
// |               and register file (RF).                                |
// | Ports       : clk, reset     - clock, synchronous active-high reset  |
// |               ctrl           - per-cycle control bundle              |
// |               opcode, funct  - decoded fields of the current IR      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mips_mc_datapath
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int WIDTH     = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  ctrl_t      ctrl,
  output logic [5:0] opcode,
  output logic [5:0] funct
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [WIDTH-1:0] mdr_q, mdr_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] aluout_q, aluout_d;

  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] rf_rd1, rf_rd2, rf_wdata;
  logic [4:0]       rf_waddr;
  logic [WIDTH-1:0] imm_ext, jump_target;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic             unused_addr_bits;

  assign opcode      = ir_q[31:26];
  assign funct       = ir_q[5:0];
  assign imm_ext     = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  // pc_q already holds PC+4 by the time a jump executes.
  assign jump_target = {pc_q[WIDTH-1:WIDTH-4], ir_q[25:0], 2'b00};

  // Byte address -> word address; upper bits are dropped so accesses wrap.
  assign mem_addr         = ctrl.iord ? aluout_q : pc_q;
  assign unused_addr_bits = ^{mem_addr[WIDTH-1:AW+2], mem_addr[1:0]};

  mips_mc_mem #(
    .MEM_WORDS (MEM_WORDS),
    .WIDTH     (WIDTH)
  ) MEM (
    .clk   (clk),
    .we    (ctrl.mem_we),
    .addr  (mem_addr[AW+1:2]),
    .wdata (b_q),
    .rdata (mem_rdata)
  );

  assign rf_waddr = ctrl.reg_dst_rd ? ir_q[15:11] : ir_q[20:16];
  assign rf_wdata = ctrl.mem_to_reg ? mdr_q : aluout_q;

  mips_mc_regfile #(
    .WIDTH (WIDTH)
  ) RF (
    .clk (clk),
    .we  (ctrl.reg_we),
    .wa  (rf_waddr),
    .wd  (rf_wdata),
    .ra1 (ir_q[25:21]),
    .ra2 (ir_q[20:16]),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  // ALU operand selection and operation
  assign alu_a = ctrl.srca_reg ? a_q : pc_q;

  always_comb begin
    alu_b = b_q;
    case (ctrl.srcb)
      SRCB_B:       alu_b = b_q;
      SRCB_FOUR:    alu_b = WIDTH'(4);
      SRCB_IMM:     alu_b = imm_ext;
      SRCB_IMM_SH2: alu_b = {imm_ext[WIDTH-3:0], 2'b00};
      default:      alu_b = b_q;
    endcase
  end

  always_comb begin
    alu_y = '0;
    case (ctrl.alu_ctrl)
      ALU_ADD: alu_y = alu_a + alu_b;
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_y = '0;
    endcase
  end

  // Next-state of the architectural/pipeline registers
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ctrl.ir_we     ? mem_rdata : ir_q;
    mdr_d    = ctrl.mdr_we    ? mem_rdata : mdr_q;
    a_d      = ctrl.ab_we     ? rf_rd1    : a_q;
    b_d      = ctrl.ab_we     ? rf_rd2    : b_q;
    aluout_d = ctrl.aluout_we ? alu_y     : aluout_q;
    // Branch target was parked in ALUOut during DECODE.
    if (ctrl.pc_we || (ctrl.pc_we_beq && (a_q == b_q))) begin
      case (ctrl.pc_src)
        PCSRC_ALU:    pc_d = alu_y;
        PCSRC_ALUOUT: pc_d = aluout_q;
        PCSRC_JUMP:   pc_d = jump_target;
        default:      pc_d = alu_y;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_mc_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mips_mc_mem                                            |
// | Description : Unified instruction/data memory. Combinational read,   |
// |               synchronous write. Contents are not touched by reset.  |
// | Ports       : clk   - clock                                          |
// |               we    - write enable                                   |
// |               addr  - word address (wraps modulo MEM_WORDS)          |
// |               wdata - write data                                     |
// |               rdata - read data                                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mips_mc_mem #(
  parameter int MEM_WORDS = 64,
  parameter int WIDTH     = 32,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:MEM_WORDS-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/mips_mc_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mips_mc_regfile                                        |
// | Description : 32-entry register file, two combinational read ports,  |
// |               one synchronous write port. $0 is hard-wired to zero.  |
// |               Reset does not clear the contents.                     |
// | Ports       : clk           - clock                                  |
// |               we, wa, wd    - write enable, address, data            |
// |               ra1/rd1       - read port 1 address/data               |
// |               ra2/rd2       - read port 2 address/data               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mips_mc_regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             we,
  input  logic [4:0]       wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [4:0]       ra1,
  input  logic [4:0]       ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);

  logic [WIDTH-1:0] registers [0:31];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) begin
      registers[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : registers[ra2];

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mips_multicycle_top                                    |
// | Description : Multi-cycle 32-bit MIPS subset processor. Holds the    |
// |               control FSM and instantiates the datapath (DP).        |
// | Ports       : clk   - system clock, rising-edge                      |
// |               reset - synchronous active-high reset                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mips_multicycle_top
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int WIDTH     = 32
) (
  input logic clk,
  input logic reset
);

  state_t     state_q, state_d;
  ctrl_t      ctrl;
  logic [5:0] opcode;
  logic [5:0] funct;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctrl    = '0;
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_we  = 1'b1;
        ctrl.pc_we  = 1'b1;
        ctrl.srcb   = SRCB_FOUR;
        ctrl.pc_src = PCSRC_ALU;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        ctrl.ab_we     = 1'b1;
        ctrl.aluout_we = 1'b1;
        ctrl.srcb      = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ctrl.srca_reg  = 1'b1;
        ctrl.srcb      = SRCB_IMM;
        ctrl.aluout_we = 1'b1;
        state_d        = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        ctrl.iord   = 1'b1;
        ctrl.mdr_we = 1'b1;
        state_d     = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.reg_we     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_we = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECUTE: begin
        ctrl.srca_reg  = 1'b1;
        ctrl.srcb      = SRCB_B;
        ctrl.alu_ctrl  = funct_to_alu(funct);
        ctrl.aluout_we = 1'b1;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        // Unknown functs (including the all-zero word) retire without a write.
        ctrl.reg_we     = funct_valid(funct);
        ctrl.reg_dst_rd = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.srca_reg  = 1'b1;
        ctrl.pc_we_beq = 1'b1;
        ctrl.pc_src    = PCSRC_ALUOUT;
        state_d        = S_FETCH;
      end
      S_ADDIEXEC: begin
        ctrl.srca_reg  = 1'b1;
        ctrl.srcb      = SRCB_IMM;
        ctrl.aluout_we = 1'b1;
        state_d        = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctrl.reg_we = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_we  = 1'b1;
        ctrl.pc_src = PCSRC_JUMP;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset aborts the current instruction: no architectural side effects.
    if (reset) begin
      ctrl    = '0;
      state_d = S_FETCH;
    end
  end

  mips_mc_datapath #(
    .MEM_WORDS (MEM_WORDS),
    .WIDTH     (WIDTH)
  ) DP (
    .clk    (clk),
    .reset  (reset),
    .ctrl   (ctrl),
    .opcode (opcode),
    .funct  (funct)
  );

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_top.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mips_multicycle_top                                 |
// | Description : Self-checking bench for mips_multicycle_top. An        |
// |               instruction-level interpreter predicts, for every      |
// |               retired instruction, its latency, the following PC    |
// |               and any register/memory write; a monitor compares      |
// |               those predictions each time the core returns to FETCH. |
// | Ports       : none                                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mips_multicycle_top;
  import mips_pkg::*;

  localparam int MEM_WORDS = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mips_multicycle_top #(
    .MEM_WORDS (MEM_WORDS),
    .WIDTH     (32)
  ) dut (
    .clk   (clk),
    .reset (reset)
  );

  typedef struct {
    int unsigned lat;
    logic [31:0] pc;
    bit          rw;
    int          ridx;
    logic [31:0] rval;
    bit          mw;
    int          midx;
    logic [31:0] mval;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned retire_cycles = 0;

  logic [31:0] img   [MEM_WORDS];
  logic [31:0] m_mem [MEM_WORDS];
  logic [31:0] m_reg [32];
  logic [31:0] m_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endtask

  // ---------------- instruction-level reference model ----------------
  function automatic logic [31:0] sext(input logic [15:0] i);
    return {{16{i[15]}}, i};
  endfunction

  function automatic int widx(input logic [31:0] byte_addr);
    return int'((byte_addr / 4) % MEM_WORDS);
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic model_step();
    exp_t        e;
    logic [31:0] ins, nxt, va, vb, addr, res;
    logic [5:0]  op, fn;
    int          rs, rt, rd;
    bit          ok;
    ins = m_mem[widx(m_pc)];
    op  = ins[31:26];
    fn  = ins[5:0];
    rs  = int'(ins[25:21]);
    rt  = int'(ins[20:16]);
    rd  = int'(ins[15:11]);
    va  = m_reg[rs];
    vb  = m_reg[rt];
    nxt = m_pc + 32'd4;
    e   = '{lat: 2, pc: 32'h0, rw: 1'b0, ridx: 0, rval: 32'h0, mw: 1'b0, midx: 0, mval: 32'h0};
    case (op)
      6'h00: begin
        e.lat = 4;
        ok    = 1'b1;
        res   = 32'h0;
        case (fn)
          6'h20:   res = va + vb;
          6'h22:   res = va - vb;
          6'h24:   res = va & vb;
          6'h25:   res = va | vb;
          6'h2A:   res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          default: ok = 1'b0;
        endcase
        if (ok) begin
          if (rd != 0) m_reg[rd] = res;
          e.rw = 1'b1; e.ridx = rd; e.rval = m_reg[rd];
        end
      end
      6'h23: begin
        e.lat = 5;
        addr  = va + sext(ins[15:0]);
        if (rt != 0) m_reg[rt] = m_mem[widx(addr)];
        e.rw = 1'b1; e.ridx = rt; e.rval = m_reg[rt];
      end
      6'h2B: begin
        e.lat = 4;
        addr  = va + sext(ins[15:0]);
        m_mem[widx(addr)] = vb;
        e.mw = 1'b1; e.midx = widx(addr); e.mval = vb;
      end
      6'h04: begin
        e.lat = 3;
        if (va == vb) nxt = m_pc + 32'd4 + (sext(ins[15:0]) * 4);
      end
      6'h08: begin
        e.lat = 4;
        if (rt != 0) m_reg[rt] = va + sext(ins[15:0]);
        e.rw = 1'b1; e.ridx = rt; e.rval = m_reg[rt];
      end
      6'h02: begin
        e.lat = 3;
        nxt   = {nxt[31:28], ins[25:0], 2'b00};
      end
      default: e.lat = 2;
    endcase
    m_pc = nxt;
    e.pc = m_pc;
    exp_q.push_back(e);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    bit          started;
    int unsigned cyc;
    exp_t        e;
    started = 1'b0;
    cyc     = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        started = 1'b0;
        cyc     = 0;
      end else if (dut.state_q == S_FETCH) begin
        if (started && (exp_q.size() > 0)) begin
          e = exp_q.pop_front();
          check("latency", 32'(cyc), 32'(e.lat));
          check("pc", dut.DP.pc_q, e.pc);
          if (e.rw) check($sformatf("reg[%0d]", e.ridx), dut.DP.RF.registers[e.ridx], e.rval);
          if (e.mw) check($sformatf("mem[%0d]", e.midx), dut.DP.MEM.mem[e.midx], e.mval);
          retire_cycles += cyc;
        end
        started = 1'b1;
        cyc     = 1;
      end else begin
        cyc++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_img();
    for (int i = 0; i < MEM_WORDS; i++) img[i] = 32'h0;
  endtask

  task automatic load_and_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < MEM_WORDS; i++) begin
      dut.DP.MEM.mem[i] <= img[i];
      m_mem[i] = img[i];
    end
    for (int i = 0; i < 32; i++) begin
      dut.DP.RF.registers[i] <= 32'h0;
      m_reg[i] = 32'h0;
    end
    m_pc = 32'h0;
    exp_q.delete();
    retire_cycles = 0;
    repeat (2) @(negedge clk);
    check("reset pc", dut.DP.pc_q, 32'h0);
    check("reset state", 32'(dut.state_q), 32'(S_FETCH));
    check("reset ir", dut.DP.ir_q, 32'h0);
    check("reset aluout", dut.DP.aluout_q, 32'h0);
    check("reset a/b/mdr", dut.DP.a_q | dut.DP.b_q | dut.DP.mdr_q, 32'h0);
  endtask

  task automatic release_and_drain(input int steps);
    int budget;
    for (int k = 0; k < steps; k++) model_step();
    @(posedge clk);
    #1 reset = 1'b0;
    budget = steps * 6 + 20;
    while ((exp_q.size() != 0) && (budget > 0)) begin
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      check("retire timeout (instructions left)", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
  endtask

  task automatic gen_random_prog();
    int          kind;
    logic [5:0]  fns [6];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    clear_img();
    for (int i = 48; i < MEM_WORDS; i++) img[i] = $urandom;
    for (int i = 0; i < 8; i++) img[i] = enc_i(6'h08, 0, i + 1, 16'($urandom));
    for (int i = 8; i < 32; i++) begin
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1, 2: img[i] = enc_r(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                int'($urandom_range(0, 15)), fns[$urandom_range(0, 5)]);
        4: img[i] = enc_i(6'h23, 0, int'($urandom_range(0, 15)), 16'(192 + 4 * $urandom_range(0, 15)));
        5: img[i] = enc_i(6'h2B, 0, int'($urandom_range(0, 15)), 16'(192 + 4 * $urandom_range(0, 15)));
        6: img[i] = enc_i(6'h04, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          16'($urandom_range(0, 3)));
        7: img[i] = {6'h02, 26'(i + 1 + int'($urandom_range(0, 3)))};
        8: img[i] = {6'h3F, 26'($urandom)};
        default: img[i] = enc_i(6'h08, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                                16'($urandom));
      endcase
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin : driver
    int budget;
    bit found;

    // Basic program: addi/addi/add/sw/lw/beq-to-self
    clear_img();
    img[0] = 32'h20080005; img[1] = 32'h20090003; img[2] = 32'h01095020;
    img[3] = 32'hAC0A0000; img[4] = 32'h8C0B0000; img[5] = 32'h11080000;
    load_and_reset();
    release_and_drain(6);
    check("p1 reg8", dut.DP.RF.registers[8], 32'd5);
    check("p1 reg9", dut.DP.RF.registers[9], 32'd3);
    check("p1 reg10", dut.DP.RF.registers[10], 32'd8);
    check("p1 reg11", dut.DP.RF.registers[11], 32'd8);
    check("p1 mem0", dut.DP.MEM.mem[0], 32'd8);
    check("p1 cycles to pc 0x18", 32'(retire_cycles), 32'd24);

    // sub / slt / and / or with a negative operand
    clear_img();
    img[0] = 32'h2008FFFF; img[1] = 32'h20090001; img[2] = 32'h01285022;
    img[3] = 32'h0109582A; img[4] = 32'h01096024; img[5] = 32'h01096825;
    load_and_reset();
    release_and_drain(6);
    check("p2 reg10 sub", dut.DP.RF.registers[10], 32'd2);
    check("p2 reg11 slt", dut.DP.RF.registers[11], 32'd1);
    check("p2 reg12 and", dut.DP.RF.registers[12], 32'd1);
    check("p2 reg13 or", dut.DP.RF.registers[13], 32'hFFFFFFFF);

    // beq not taken, jump, write to $0
    clear_img();
    img[0] = 32'h20080005; img[1] = 32'h10080003; img[2] = 32'h08000003; img[3] = 32'h20000007;
    load_and_reset();
    release_and_drain(4);
    check("p3 reg0", dut.DP.RF.registers[0], 32'd0);
    check("p3 reg8", dut.DP.RF.registers[8], 32'd5);

    // Unknown opcode is a 2-cycle NOP
    clear_img();
    img[0] = 32'hFC000000; img[1] = 32'h20080005;
    load_and_reset();
    release_and_drain(2);
    check("p4 reg8", dut.DP.RF.registers[8], 32'd5);
    check("p4 cycles", 32'(retire_cycles), 32'd6);

    // Reset during MEMWRITE of a store aborts the write
    clear_img();
    img[0] = 32'h200A0009; img[1] = 32'hAC0A00C0;
    load_and_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    found  = 1'b0;
    budget = 20;
    while (!found && (budget > 0)) begin
      @(negedge clk);
      budget--;
      if (dut.state_q == S_MEMWRITE) found = 1'b1;
    end
    check("reached MEMWRITE", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort mem48", dut.DP.MEM.mem[48], 32'h0);
    check("abort pc", dut.DP.pc_q, 32'h0);
    check("abort state", 32'(dut.state_q), 32'(S_FETCH));
    check("abort reg10", dut.DP.RF.registers[10], 32'd9);

    // Randomised programs against the interpreter
    for (int p = 0; p < 6; p++) begin
      gen_random_prog();
      load_and_reset();
      release_and_drain(40);
    end

    @(posedge clk);
    #1 reset = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
